// File: rtl/arms_cmd_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arms_pkg: command encodings, FSM state type and data width.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package arms_pkg;

  localparam int DATA_W = 4;

  localparam logic [1:0] CMD_RST_CNT    = 2'b00;
  localparam logic [1:0] CMD_LOAD_LIMIT = 2'b01;
  localparam logic [1:0] CMD_COUNT_UP   = 2'b10;
  localparam logic [1:0] CMD_COUNT_DOWN = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arms_cmd_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arms_cmd_if: requester-side command bus (valid/con/data/ready).      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface arms_cmd_if
  import arms_pkg::*;
#(
  parameter int NREQ = 2
) ();

  logic [NREQ-1:0]        req_valid;
  logic [2*NREQ-1:0]      req_con;
  logic [DATA_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        req_ready;

  modport master (output req_valid, output req_con, output req_data, input req_ready);
  modport slave  (input req_valid, input req_con, input req_data, output req_ready);

endinterface
`default_nettype wire

// File: rtl/arms_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arms_rr_arbiter: round-robin one-hot grant, pointer = last grant + 1. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arms_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid_i,
  input  logic            advance_i,
  output logic [NREQ-1:0] grant_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] win_idx_d;
  logic          found_d;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IW-1:0];
  endfunction

  always_comb begin
    grant_o   = '0;
    win_idx_d = '0;
    found_d   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_d && valid_i[wrap_idx(ptr_q, k)]) begin
        found_d            = 1'b1;
        win_idx_d          = wrap_idx(ptr_q, k);
        grant_o[win_idx_d] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (win_idx_d == IW'(NREQ - 1)) ? '0 : win_idx_d + IW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/arms_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arms_cmd_arbiter: arbitrates counter commands and times STRB vs      |
// | CON/DATA. Option: ARMS_LIMIT_SHADOW_EN adds the AT_LIMIT shadow.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arms_cmd_arbiter
  import arms_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int STRB_SETUP = 1,
  parameter int STRB_WIDTH = 1,
  parameter int STRB_HOLD  = 1
) (
  input  logic              clk,
  input  logic              rst,
  arms_cmd_if.slave         req,
  output logic              strb_o,
  output logic [1:0]        con_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] cout_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              at_limit_o
);

  localparam int CW = $clog2(max3(STRB_SETUP, STRB_WIDTH, STRB_HOLD)) + 1;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              strb_q;
  logic              done_q;
  logic [1:0]        con_q;
  logic [DATA_W-1:0] data_q;

  logic [NREQ-1:0]   grant_d;
  logic              advance_d;
  logic [1:0]        win_con_d;
  logic [DATA_W-1:0] win_data_d;

  assign advance_d     = (state_q == IDLE) && (|req.req_valid) && !rst;
  assign req.req_ready = ((state_q == IDLE) && !rst) ? grant_d : '0;

  arms_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (req.req_valid),
    .advance_i (advance_d),
    .grant_o   (grant_d)
  );

  always_comb begin
    win_con_d  = '0;
    win_data_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_d[i]) begin
        win_con_d  = req.req_con[2*i +: 2];
        win_data_d = req.req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      strb_q  <= 1'b0;
      done_q  <= 1'b0;
      con_q   <= '0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req.req_valid) begin
            con_q   <= win_con_d;
            data_q  <= win_data_d;
            cnt_q   <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == CW'(STRB_SETUP - 1)) begin
            cnt_q   <= '0;
            strb_q  <= 1'b1;
            state_q <= PULSE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PULSE: begin
          if (cnt_q == CW'(STRB_WIDTH - 1)) begin
            cnt_q   <= '0;
            strb_q  <= 1'b0;
            done_q  <= (STRB_HOLD == 1);
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HOLD: begin
          // DONE is registered, so it is raised one cycle before the last HOLD cycle ends.
          if (cnt_q == CW'(STRB_HOLD - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q  <= cnt_q + CW'(1);
            done_q <= (STRB_HOLD >= 2) && (cnt_q == CW'(STRB_HOLD - 2));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign strb_o = strb_q;
  assign con_o  = con_q;
  assign data_o = data_q;
  assign done_o = done_q;
  assign busy_o = (state_q != IDLE);

`ifdef ARMS_LIMIT_SHADOW_EN
  logic [DATA_W-1:0] shadow_q;
  logic              at_limit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= '0;
      at_limit_q <= 1'b0;
    end else begin
      if (done_q && (con_q == CMD_LOAD_LIMIT)) shadow_q <= data_q;
      at_limit_q <= (cout_i == shadow_q);
    end
  end

  assign at_limit_o = at_limit_q;
`else
  logic w_unused_cout;
  assign w_unused_cout = ^cout_i;
  assign at_limit_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arms_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_arms_cmd_arbiter: directed bench, default and S=2/W=3/H=2 DUTs.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_arms_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cout = 4'h0;

  always #5 clk = ~clk;

  arms_cmd_if #(.NREQ(2)) if0 ();
  arms_cmd_if #(.NREQ(2)) if1 ();

  logic       strb0, busy0, done0, atl0;
  logic [1:0] con0;
  logic [3:0] data0;
  logic       strb1, busy1, done1, atl1;
  logic [1:0] con1;
  logic [3:0] data1;

  arms_cmd_arbiter #(.NREQ(2), .STRB_SETUP(1), .STRB_WIDTH(1), .STRB_HOLD(1)) dut (
    .clk(clk), .rst(rst), .req(if0), .strb_o(strb0), .con_o(con0), .data_o(data0),
    .cout_i(cout), .busy_o(busy0), .done_o(done0), .at_limit_o(atl0)
  );

  arms_cmd_arbiter #(.NREQ(2), .STRB_SETUP(2), .STRB_WIDTH(3), .STRB_HOLD(2)) dut2 (
    .clk(clk), .rst(rst), .req(if1), .strb_o(strb1), .con_o(con1), .data_o(data1),
    .cout_i(cout), .busy_o(busy1), .done_o(done1), .at_limit_o(atl1)
  );

  int checks   = 0;
  int failures = 0;

`ifdef ARMS_LIMIT_SHADOW_EN
  localparam logic EXP_AT_LIMIT = 1'b1;
`else
  localparam logic EXP_AT_LIMIT = 1'b0;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if0.req_valid = 2'b11; if0.req_con = 4'b1110; if0.req_data = 8'h53;
    if1.req_valid = 2'b00; if1.req_con = 4'b0000; if1.req_data = 8'h00;
    tick; tick;
    @(negedge clk);
    checks++;
    if ({if0.req_ready, strb0, con0, data0, busy0, done0, atl0} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000000000",
               {if0.req_ready, strb0, con0, data0, busy0, done0, atl0});
    end
    tick; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if0.req_ready !== 2'b01) begin
      failures++; $display("FAIL first_grant got=%b exp=01", if0.req_ready);
    end
    tick; if0.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({busy0, con0, data0} !== {1'b1, 2'b10, 4'h3}) begin
      failures++; $display("FAIL first_cmd got=%b exp=1100011", {busy0, con0, data0});
    end
    tick; tick; tick;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin
      failures++; $display("FAIL first_idle got=%b exp=0", busy0);
    end
  endtask

  task automatic test_single;
    tick;
    if0.req_valid = 2'b01; if0.req_con = 4'b0001; if0.req_data = 8'h02;
    @(negedge clk);
    checks++;
    if ({if0.req_ready, strb0, busy0} !== 4'b0100) begin
      failures++; $display("FAIL single_t0 got=%b exp=0100", {if0.req_ready, strb0, busy0});
    end
    for (int c = 1; c <= 4; c++) begin
      tick;
      if (c == 1) if0.req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if ({strb0, done0, busy0} !== {c == 2, c == 3, c <= 3}) begin
        failures++;
        $display("FAIL single_timing c=%0d got=%b exp=%b", c, {strb0, done0, busy0},
                 {c == 2, c == 3, c <= 3});
      end
      checks++;
      if ({con0, data0} !== {2'b01, 4'b0010}) begin
        failures++; $display("FAIL single_condata c=%0d got=%b exp=010010", c, {con0, data0});
      end
    end
  endtask

  task automatic test_fairness;
    tick; rst = 1'b1;
    tick; rst = 1'b0;
    if0.req_valid = 2'b11; if0.req_con = 4'b1110; if0.req_data = 8'h00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (if0.req_ready !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL fair_grant k=%0d got=%b", k, if0.req_ready);
      end
      tick;
      @(negedge clk);
      checks++;
      if (con0 !== ((k % 2 == 1) ? 2'b11 : 2'b10)) begin
        failures++; $display("FAIL fair_con k=%0d got=%b", k, con0);
      end
      tick; tick; tick;
    end
    if0.req_valid = 2'b00;
  endtask

  task automatic test_params;
    tick;
    if1.req_valid = 2'b01; if1.req_con = 4'b0011; if1.req_data = 8'h0A;
    @(negedge clk);
    checks++;
    if (if1.req_ready !== 2'b01) begin
      failures++; $display("FAIL param_grant got=%b exp=01", if1.req_ready);
    end
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (c == 1) if1.req_valid = 2'b00;
      if (c == 8) begin
        if1.req_valid = 2'b10; if1.req_con = 4'b0100;
      end
      @(negedge clk);
      checks++;
      if ({strb1, done1, busy1} !== {(c >= 3 && c <= 5), c == 7, c <= 7}) begin
        failures++;
        $display("FAIL param_timing c=%0d got=%b exp=%b", c, {strb1, done1, busy1},
                 {(c >= 3 && c <= 5), c == 7, c <= 7});
      end
      if (c == 1) begin
        checks++;
        if ({con1, data1} !== {2'b11, 4'hA}) begin
          failures++; $display("FAIL param_condata got=%b exp=111010", {con1, data1});
        end
      end
      if (c == 8) begin
        checks++;
        if (if1.req_ready !== 2'b10) begin
          failures++; $display("FAIL param_next_grant got=%b exp=10", if1.req_ready);
        end
      end
    end
    tick; if1.req_valid = 2'b00;
    repeat (7) tick;
  endtask

  task automatic test_rst_mid;
    tick;
    if0.req_valid = 2'b10; if0.req_con = 4'b0110; if0.req_data = 8'h53;
    @(negedge clk);
    checks++;
    if (if0.req_ready !== 2'b10) begin
      failures++; $display("FAIL rstmid_grant got=%b exp=10", if0.req_ready);
    end
    tick; tick;
    @(negedge clk);
    checks++;
    if (strb0 !== 1'b1) begin
      failures++; $display("FAIL rstmid_pulse got=%b exp=1", strb0);
    end
    rst = 1'b1; if0.req_valid = 2'b11;
    #1;
    checks++;
    if (if0.req_ready !== 2'b00) begin
      failures++; $display("FAIL rstmid_ready_forced got=%b exp=00", if0.req_ready);
    end
    tick;
    @(negedge clk);
    checks++;
    if ({strb0, done0, con0, busy0, if0.req_ready} !== 7'b0000000) begin
      failures++;
      $display("FAIL rstmid_abort got=%b exp=0000000", {strb0, done0, con0, busy0, if0.req_ready});
    end
    tick; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if0.req_ready !== 2'b01) begin
      failures++; $display("FAIL rstmid_idx0_first got=%b exp=01", if0.req_ready);
    end
    tick; if0.req_valid = 2'b10;
    @(negedge clk);
    checks++;
    if (con0 !== 2'b10) begin
      failures++; $display("FAIL rstmid_con0 got=%b exp=10", con0);
    end
    tick; tick; tick;
    @(negedge clk);
    checks++;
    if (if0.req_ready !== 2'b10) begin
      failures++; $display("FAIL rstmid_idx1_next got=%b exp=10", if0.req_ready);
    end
    tick; if0.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if ({con0, data0} !== {2'b01, 4'h5}) begin
      failures++; $display("FAIL rstmid_retry_data got=%b exp=010101", {con0, data0});
    end
    tick; tick; tick;
  endtask

  task automatic test_at_limit;
    tick;
    cout = 4'h0;
    if0.req_valid = 2'b01; if0.req_con = 4'b0001; if0.req_data = 8'h02;
    @(negedge clk);
    checks++;
    if (if0.req_ready !== 2'b01) begin
      failures++; $display("FAIL limit_grant got=%b exp=01", if0.req_ready);
    end
    tick; if0.req_valid = 2'b00;
    tick; tick; tick;
    cout = 4'h1;
    tick; cout = 4'h2;
    @(negedge clk);
    checks++;
    if (atl0 !== 1'b0) begin
      failures++; $display("FAIL at_limit_below got=%b exp=0", atl0);
    end
    tick; cout = 4'h3;
    @(negedge clk);
    checks++;
    if (atl0 !== EXP_AT_LIMIT) begin
      failures++; $display("FAIL at_limit_hit got=%b exp=%b", atl0, EXP_AT_LIMIT);
    end
    tick;
    @(negedge clk);
    checks++;
    if (atl0 !== 1'b0) begin
      failures++; $display("FAIL at_limit_above got=%b exp=0", atl0);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_params;
    test_rst_mid;
    test_at_limit;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arms_cmd_arbiter.md
# arms_cmd_arbiter

Command sequencer and round-robin arbiter in front of the ARMS_COUNTER command port. It accepts counter commands (reset, load limit, count up, count down) from NREQ independent requesters and grants them one at a time. For each granted command it drives CON/DATA with setup time, a clean STRB pulse and hold time, all synchronous to CLK. Requesters no longer hand-time STRB against CON/DATA.

## Interface
- NREQ, 2: number of requesters (2..8)
- STRB_SETUP, 1: cycles CON/DATA are stable before STRB rises (>=1)
- STRB_WIDTH, 1: cycles STRB is high (>=1)
- STRB_HOLD, 1: cycles CON/DATA are held after STRB falls (>=1)

Ports:
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- REQ_VALID  in  NREQ  requester i has a command pending
- REQ_CON  in  2*NREQ  command of requester i in bits [2i+1:2i]
- REQ_DATA  in  4*NREQ  data of requester i in bits [4i+3:4i]; used only for LOAD
- REQ_READY  out  NREQ  one-hot; command of requester i accepted this cycle
- STRB  out  1  strobe to counter, registered
- CON  out  2  command to counter, registered
- DATA  out  4  data to counter, registered
- COUT  in  4  counter output (used by the configurable feature only)
- BUSY  out  1  command in flight (not IDLE)
- DONE  out  1  one-cycle pulse in the last HOLD cycle
- AT_LIMIT  out  1  COUT equals last loaded limit (see Configuration)

## Operation
- Command encodings: 00 RST_CNT, 01 LOAD_LIMIT, 10 COUNT_UP, 11 COUNT_DOWN.
- FSM states: IDLE -> SETUP -> PULSE -> HOLD -> IDLE.
- IDLE:
  - If any REQ_VALID is set, the arbiter picks the winner. REQ_READY[winner]=1 in this same cycle (combinational from state and VALID).
  - CON/DATA load the winner's fields at the clock edge, and the FSM goes to SETUP.
- SETUP: STRB_SETUP cycles with STRB=0.
- PULSE: STRB_WIDTH cycles with STRB=1.
- HOLD: STRB_HOLD cycles with STRB=0. DONE=1 in the final HOLD cycle, then IDLE.
- CON/DATA hold their value after the command completes and change only on the next grant.
- Arbitration:
  - Round-robin. The pointer starts one past the last granted index and searches upward with wrap.
  - After reset, index 0 has highest priority.
  - The pointer updates only on a grant.
  - A requester that drops VALID before it is granted loses nothing.
- Requesters must hold VALID/CON/DATA stable until READY. VALID seen while BUSY is ignored until IDLE.
- A single VALID requester is granted every cycle it is IDLE-eligible. No starvation: any VALID requester is granted within NREQ commands.

## Timing
- Handshake at cycle t:
  - CON/DATA valid from t+1.
  - STRB high cycles t+STRB_SETUP+1 .. t+STRB_SETUP+STRB_WIDTH.
  - DONE at t+S+W+H (S = STRB_SETUP, W = STRB_WIDTH, H = STRB_HOLD).
  - Next grant possible at t+S+W+H+1.
- Defaults: 4 cycles per command; STRB high at t+2 only; DONE at t+3.
- BUSY is high from t+1 through the DONE cycle.
- Reset values: STRB=0, CON=00, DATA=0000, BUSY=0, DONE=0, REQ_READY=0 (forced while RST=1), AT_LIMIT=0, round-robin pointer=0.
- RST mid-command:
  - The FSM returns to IDLE at the edge, and STRB is low from the next cycle.
  - No DONE is issued. The aborted command is not retried by this block.
- Counters for SETUP/PULSE/HOLD are sized to $clog2 of the maximum parameter plus 1. They are not affected by COUT.

## Configuration
- ARMS_LIMIT_SHADOW_EN defined:
  - A 4-bit shadow register captures DATA when a LOAD_LIMIT command reaches its DONE cycle. It is reset to 0000.
  - AT_LIMIT is registered as (COUT == shadow), so it lags COUT by one cycle.
- ARMS_LIMIT_SHADOW_EN undefined: no shadow register, AT_LIMIT tied to 0, and COUT is unused.

## Structure
- Package arms_pkg holds:
  - command encoding constants CMD_RST_CNT, CMD_LOAD_LIMIT, CMD_COUNT_UP, CMD_COUNT_DOWN;
  - the FSM state typedef (IDLE, SETUP, PULSE, HOLD);
  - the 4-bit data width constant.
- Sub-module arms_rr_arbiter (NREQ parameter): inputs VALID vector and advance; outputs one-hot grant. It holds the rotating pointer.
- Top level holds the FSM, phase counter, output registers and the optional shadow.

## Test plan
- Reset: hold RST 2 cycles with REQ_VALID=11 -> STRB=0, CON=00, DATA=0000, REQ_READY=00, BUSY=0. First grant goes to index 0 in the first cycle after RST drops.
- Single request, defaults: REQ0 LOAD_LIMIT DATA=0010 at t -> REQ_READY=01 at t; CON=01, DATA=0010 at t+1; STRB=1 only at t+2; DONE at t+3; BUSY t+1..t+3.
- Fairness: REQ0 COUNT_UP and REQ1 COUNT_DOWN both held VALID -> grants at t, t+4, t+8, t+12 go 0,1,0,1; CON alternates 10, 11.
- Parameters S=2, W=3, H=2: grant at t -> STRB high t+3..t+5, DONE at t+7, next grant at t+8.
- RST asserted during PULSE, with REQ1 still VALID -> STRB=0 next cycle, no DONE, CON=00; after RST drops, REQ1 (index 1) granted only after index 0 if both valid, else immediately.
- With ARMS_LIMIT_SHADOW_EN: LOAD_LIMIT 0010 then drive COUT 0001 -> 0010 -> AT_LIMIT=1 one cycle after COUT=0010. Without the macro, the same stimulus gives AT_LIMIT=0 throughout.
